grostl_shift_bytes: RTL and testbench
=====================================

# grostl_shift_bytes

Column-serial ShiftBytes stage for the 64-bit Grøstl-256 datapath.
- Accepts state columns one per cycle from the AddRoundConstant/SubBytes stage.
- Buffers a full 8-column state, then emits shifted columns one per cycle to the MixBytes stage.
- Double-buffered (ping-pong), so one state fills while the previous one drains, giving sustained one-column-per-cycle throughput.
- Supports both the P and Q shift vectors, selected per state block.

## Interface
Parameters
- None. Column count (8), bytes per column (8) and byte width (8) are fixed by Grøstl-256.

Ports
- clk  in  1  Rising-edge clock; the block's only clock.
- rst  in  1  Asynchronous, active-high reset.
- in_valid  in  1  Upstream column valid.
- in_ready  out  1  Block can accept a column.
- in_q  in  1  Shift vector select (0 = P, 1 = Q). Sampled only with column 0 of a block.
- in_col  in  [0:7][7:0]  Input column; byte 0 = row 0, held in the MSB byte.
- out_valid  out  1  Shifted column valid.
- out_ready  in  1  Downstream (MixBytes stage) can accept.
- out_col  out  [0:7][7:0]  Shifted column; same byte order as in_col.
- out_q  out  1  P/Q flag of the block being drained.
- out_idx  out  3  Index (0..7) of the column on out_col.
- out_last  out  1  High when out_idx == 7 and out_valid is high.

## Operation
Storage
- Two banks, 0 and 1. Each bank holds 8 × 64-bit columns, a q flag and a full flag.

Write side: write pointer wsel, column counter wcnt[2:0]
- in_ready = ~full[wsel].
- On accept (in_valid & in_ready):
  - Store in_col into bank[wsel] column wcnt.
  - If wcnt == 0, also latch in_q into q[wsel].
  - If wcnt == 7: set full[wsel], toggle wsel, wcnt ← 0. Otherwise wcnt increments.

Read side: read pointer rsel, column counter rcnt[2:0]
- out_valid = full[rsel]; out_idx = rcnt; out_q = q[rsel].
- out_col byte i = bank[rsel] column ((rcnt + σ[i]) mod 8), byte i.
  - σ_P = {0,1,2,3,4,5,6,7}.
  - σ_Q = {1,3,5,7,0,2,4,6}.
- On transfer (out_valid & out_ready):
  - If rcnt == 7: clear full[rsel], toggle rsel, rcnt ← 0. Otherwise rcnt increments.

Ordering and boundary conditions
- Column index arithmetic is 3-bit and wraps modulo 8 naturally.
- Blocks are drained in the order they were filled; the per-block q flag is never mixed between blocks.
- Both banks full: in_ready = 0; upstream stalls until the drain of bank[rsel] completes.
- Both banks empty: out_valid = 0; out_col shows bank[rsel] contents and is don't-care to consumers.
- Simultaneous accept and transfer is always legal:
  - Write targets a non-full bank; read targets a full bank.
  - They can never touch the same bank in the same cycle, so no hazard logic is required.
- Stall behaviour:
  - out_ready low holds rcnt, out_col, out_idx and out_q stable.
  - in_valid low holds wcnt; partially written columns are kept.
- Reset mid-block discards every partial and full block. A column presented in the reset-release cycle is accepted as column 0 of bank 0.

Reset values
- full = 0, wsel = rsel = 0, wcnt = rcnt = 0, q = 0, bank data = 0.
- Resulting outputs: in_ready = 1, out_valid = 0, out_col = 0, out_q = 0, out_idx = 0, out_last = 0.

## Timing
- Every output is a function of registered state only. There is no combinational path from in_* to out_*, or from out_ready to in_ready.
- Fill-to-drain latency:
  - Column 7 is accepted at edge N; out_valid is high in the cycle following edge N.
  - Column 0 of that block transfers at edge N+1 if out_ready is high.
- Throughput with out_ready held high:
  - One column per cycle sustained, indefinitely.
  - in_ready never deasserts.
  - A block's first output column appears 8 cycles after its first input column.
- A bank freed by its column-7 transfer at edge M is writable (in_ready high) from the cycle after M.

## Test plan
- **P shift:** Reset, then send one block with in_q = 0, column c byte i = 8'h(c,i); out_ready held high.
  - Out col 0 = 00,11,22,33,44,55,66,77.
  - Out col 7 = 70,01,12,23,34,45,56,67.
  - out_last is high on col 7 only.
- **Q shift:** Same data with in_q = 1.
  - Out col 0 = 10,31,52,73,04,25,46,67.
  - out_q = 1 on all 8 columns.
- **Streaming:** 4 back-to-back blocks with alternating q and out_ready = 1.
  - in_ready is never low.
  - 32 outputs arrive on consecutive cycles after the first block fills.
  - The q per block matches its input.
- **Backpressure:** out_ready = 0 while sending 3 blocks.
  - in_ready drops after 16 accepted columns.
  - Raising out_ready drains block 1, then block 2.
  - The third block is accepted once bank 0 frees.
- **Random stalls:** Random in_valid/out_ready over 200 blocks, checked against a reference model; no data loss or reordering.
- **Reset mid-operation:** Assert rst after 5 columns of block 2 (block 1 full).
  - out_valid = 0 and in_ready = 1 immediately.
  - The next block is emitted correctly.

Source files
------------

// File: rtl/grostl_shift_bytes.sv
// Column-serial ShiftBytes stage for Grostl-256 (P and Q shift vectors).
// Ping-pong buffered: one 8-column state fills while the other drains.
module grostl_shift_bytes (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic            in_q_i,
    input  logic [0:7][7:0] in_col_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [0:7][7:0] out_col_o,
    output logic            out_q_o,
    output logic [2:0]      out_idx_o,
    output logic            out_last_o
);

    typedef logic [0:7][7:0] col_t;

    col_t       bank_q [0:1][0:7];
    logic [1:0] full_q, full_d;
    logic [1:0] qf_q, qf_d;
    logic       wsel_q, wsel_d;
    logic       rsel_q, rsel_d;
    logic [2:0] wcnt_q, wcnt_d;
    logic [2:0] rcnt_q, rcnt_d;
    logic       accept_s;
    logic       xfer_s;

    // P leaves rows in place; Q maps row r to 2r+1 (r<4) or 2(r-4) (r>=4).
    function automatic logic [2:0] sigma(input logic q, input logic [2:0] row);
        if (q) begin
            sigma = {row[1:0], ~row[2]};
        end else begin
            sigma = row;
        end
    endfunction

    // Handshakes and next-state for both write and read pointers.
    always_comb begin
        accept_s = in_valid_i & ~full_q[wsel_q];
        xfer_s   = out_ready_i & full_q[rsel_q];
        full_d   = full_q;
        qf_d     = qf_q;
        wsel_d   = wsel_q;
        rsel_d   = rsel_q;
        wcnt_d   = wcnt_q;
        rcnt_d   = rcnt_q;
        if (accept_s) begin
            if (wcnt_q == 3'd0) begin
                qf_d[wsel_q] = in_q_i;
            end else begin
                qf_d[wsel_q] = qf_q[wsel_q];
            end
            if (wcnt_q == 3'd7) begin
                full_d[wsel_q] = 1'b1;
                wsel_d         = ~wsel_q;
                wcnt_d         = 3'd0;
            end else begin
                wcnt_d = wcnt_q + 3'd1;
            end
        end else begin
            wcnt_d = wcnt_q;
        end
        // Write and read banks are always distinct, so the two updates never collide.
        if (xfer_s) begin
            if (rcnt_q == 3'd7) begin
                full_d[rsel_q] = 1'b0;
                rsel_d         = ~rsel_q;
                rcnt_d         = 3'd0;
            end else begin
                rcnt_d = rcnt_q + 3'd1;
            end
        end else begin
            rcnt_d = rcnt_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 2'b00;
            qf_q   <= 2'b00;
            wsel_q <= 1'b0;
            rsel_q <= 1'b0;
            wcnt_q <= 3'd0;
            rcnt_q <= 3'd0;
        end else begin
            full_q <= full_d;
            qf_q   <= qf_d;
            wsel_q <= wsel_d;
            rsel_q <= rsel_d;
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
        end
    end

    // Column storage for both banks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < 8; c++) begin
                    bank_q[b][c] <= '0;
                end
            end
        end else if (accept_s) begin
            bank_q[wsel_q][wcnt_q] <= in_col_i;
        end else begin
            bank_q <= bank_q;
        end
    end

    // Output decode: each row gathers its byte from a rotated column of the read bank.
    always_comb begin
        logic [2:0] src_s;
        out_col_o = '0;
        src_s     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            src_s        = rcnt_q + sigma(qf_q[rsel_q], 3'(i));
            out_col_o[i] = bank_q[rsel_q][src_s][i];
        end
    end

    assign in_ready_o  = ~full_q[wsel_q];
    assign out_valid_o = full_q[rsel_q];
    assign out_q_o     = qf_q[rsel_q];
    assign out_idx_o   = rcnt_q;
    assign out_last_o  = full_q[rsel_q] & (rcnt_q == 3'd7);

endmodule

// File: tb/tb_grostl_shift_bytes.sv
// Scoreboard bench for grostl_shift_bytes: directed P/Q, streaming,
// backpressure, random stalls and mid-block reset.
module tb_grostl_shift_bytes;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_q;
    logic [63:0] in_col;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_col;
    logic        out_q;
    logic [2:0]  out_idx;
    logic        out_last;

    int n_checks = 0;
    int n_fail   = 0;

    logic [68:0] exp_q [$];
    logic [65:0] src_q [$];

    int acc_cnt, xfer_cnt, first_acc, first_xfer, last_xfer, irdy_low;

    int sq [8] = '{1, 3, 5, 7, 0, 2, 4, 6};

    always #5 clk = ~clk;

    grostl_shift_bytes dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_q_i      (in_q),
        .in_col_i    (in_col),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_col_o   (out_col),
        .out_q_o     (out_q),
        .out_idx_o   (out_idx),
        .out_last_o  (out_last)
    );

    task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Queue one block of input columns and its 8 expected shifted columns.
    task automatic push_block(input logic q, input bit pat);
        logic [63:0] cols [8];
        logic [63:0] oc;
        int          b;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 8; i++) begin
                cols[c][63-8*i -: 8] = pat ? {4'(c), 4'(i)} : 8'($urandom);
            end
            src_q.push_back({(c == 0), q, cols[c]});
        end
        for (int c = 0; c < 8; c++) begin
            oc = 64'd0;
            for (int i = 0; i < 8; i++) begin
                b = (c + (q ? sq[i] : i)) % 8;
                oc[63-8*i -: 8] = cols[b][63-8*i -: 8];
            end
            exp_q.push_back({q, (c == 7), 3'(c), oc});
        end
    endtask

    task automatic run(input int max_cyc, input int iv_pct, input int or_pct, input bit until_empty);
        acc_cnt = 0; xfer_cnt = 0; first_acc = -1; first_xfer = -1; last_xfer = -1; irdy_low = 0;
        for (int k = 0; k < max_cyc; k++) begin
            if (until_empty && src_q.size() == 0 && exp_q.size() == 0) break;
            @(negedge clk);
            in_valid = (src_q.size() > 0) && ($urandom_range(99) < iv_pct);
            if (src_q.size() > 0) begin
                in_col = src_q[0][63:0];
                in_q   = src_q[0][65] ? src_q[0][64] : 1'($urandom_range(1));
            end
            out_ready = ($urandom_range(99) < or_pct);
            #1;
            if (src_q.size() > 0 && !in_ready) irdy_low++;
            if (in_valid && in_ready) begin
                if (acc_cnt == 0) first_acc = k;
                acc_cnt++;
                void'(src_q.pop_front());
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 69'(out_valid), 69'd0);
                end else begin
                    check("out_col", {out_q, out_last, out_idx, out_col}, exp_q.pop_front());
                end
                if (xfer_cnt == 0) first_xfer = k;
                last_xfer = k;
                xfer_cnt++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        if (until_empty) check("drain_timeout", 69'(exp_q.size() + src_q.size()), 69'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_q = 1'b0; in_col = 64'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready",  69'(in_ready),  69'd1);
        check("rst_out_valid", 69'(out_valid), 69'd0);
        check("rst_outs",      {out_q, out_last, out_idx, out_col}, 69'd0);
        rst = 1'b0;

        // P shift with a visible full block before drain
        push_block(1'b0, 1'b1);
        run(8, 100, 0, 1'b0);
        check("p_valid", 69'(out_valid), 69'd1);
        check("p_col0",  69'(out_col),   69'h0011223344556677);
        run(100, 100, 100, 1'b1);

        // Q shift
        push_block(1'b1, 1'b1);
        run(8, 100, 0, 1'b0);
        check("q_col0", 69'(out_col), 69'h1031527304254667);
        check("q_flag", 69'(out_q),   69'd1);
        run(100, 100, 100, 1'b1);

        // Streaming: 4 back-to-back blocks
        for (int b = 0; b < 4; b++) push_block(1'(b), 1'b0);
        run(200, 100, 100, 1'b1);
        check("stream_irdy_low", 69'(irdy_low), 69'd0);
        check("stream_xfers",    69'(xfer_cnt), 69'd32);
        check("stream_span",     69'(last_xfer - first_xfer), 69'd31);
        check("stream_latency",  69'(first_xfer - first_acc), 69'd8);

        // Backpressure: third block waits for a bank to free
        for (int b = 0; b < 3; b++) push_block(1'(b + 1), 1'b0);
        run(30, 100, 0, 1'b0);
        check("bp_accepts",  69'(acc_cnt),  69'd16);
        check("bp_in_ready", 69'(in_ready), 69'd0);
        run(300, 100, 100, 1'b1);

        // Random stalls
        for (int b = 0; b < 200; b++) push_block(1'($urandom_range(1)), 1'b0);
        run(20000, 70, 60, 1'b1);

        // Reset mid-operation: block 1 full, 5 columns of block 2
        push_block(1'b0, 1'b0);
        push_block(1'b1, 1'b0);
        run(13, 100, 0, 1'b0);
        check("pre_rst_accepts", 69'(acc_cnt), 69'd13);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 69'(out_valid), 69'd0);
        check("mid_rst_in_ready",  69'(in_ready),  69'd1);
        exp_q.delete();
        src_q.delete();
        push_block(1'b1, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_col   = src_q[0][63:0];
        in_q     = src_q[0][64];
        #1;
        check("release_in_ready", 69'(in_ready), 69'd1);
        if (in_ready) void'(src_q.pop_front());
        run(200, 100, 100, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
